// File: rtl/dma_reference_model.sv
// dma_reference_model: cycle-accurate decoder predicting 8237 DMA register loads/reads from CPU bus activity
// Optional feature: define ACCESS_ERROR_CHECK_EN to add the registered accessError output.
// Ports:
//   CLK, RESET_N                          clock (rising edge), asynchronous active-low reset
//   CS_N, IOR_N, IOW_N                    CPU chip select and I/O strobes, active low
//   A3..A0                                register address, A3 is MSB
//   programCondition                      DMA idle and slave-programmable
//   loadIoDataBufferFromDB/FromStatus     combinational data-buffer load predictions
//   read*                                 combinational read decodes
//   load*/clear*/masterClear              registered one-cycle write strobes
//   channel                               channel of the latest address/count access
//   internalFF                            shadow byte-pointer flip-flop
//   accessError                           (optional) illegal access seen in the previous cycle
module dma_reference_model #(
    parameter int NUM_CH = 4
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic                      CS_N,
    input  logic                      IOR_N,
    input  logic                      IOW_N,
    input  logic                      A3,
    input  logic                      A2,
    input  logic                      A1,
    input  logic                      A0,
    input  logic                      programCondition,
    output logic                      loadIoDataBufferFromDB,
    output logic                      loadIoDataBufferFromStatus,
    output logic                      readStatusReg,
    output logic                      readCurrentAddressReg,
    output logic                      readCurrentWordCountReg,
    output logic                      readTemporaryReg,
    output logic                      loadCommandReg,
    output logic                      loadModeReg,
    output logic                      loadRequestReg,
    output logic                      loadSingleMask,
    output logic                      loadAllMask,
    output logic                      clearMaskReg,
    output logic                      masterClear,
    output logic                      clearInternalFF,
    output logic                      loadBaseAddressReg,
    output logic                      loadBaseWordCountReg,
    output logic [$clog2(NUM_CH)-1:0] channel,
    output logic                      internalFF
`ifdef ACCESS_ERROR_CHECK_EN
    ,
    output logic                      accessError
`endif
);

    logic [3:0]                addr;
    logic                      acc, wr, rd, wr_start, rd_start, tog, clr;
    logic                      wr_prev_q, wr_prev_d, rd_prev_q, rd_prev_d;
    logic                      ff_q, ff_d;
    logic [15:0]               strb_q, strb_d;
    logic [$clog2(NUM_CH)-1:0] channel_q, channel_d;

    assign addr     = {A3, A2, A1, A0};
    assign acc      = !CS_N && programCondition;
    assign wr       = acc && !IOW_N && IOR_N;
    assign rd       = acc && !IOR_N && IOW_N;
    assign wr_start = wr && !wr_prev_q;
    assign rd_start = rd && !rd_prev_q;

    assign loadIoDataBufferFromDB     = wr;
    assign readCurrentAddressReg      = rd && !addr[3] && !addr[0];
    assign readCurrentWordCountReg    = rd && !addr[3] && addr[0];
    assign readStatusReg              = rd && addr == 4'd8;
    assign loadIoDataBufferFromStatus = readStatusReg;
    assign readTemporaryReg           = rd && addr == 4'd13;

    // strb_q holds the one-hot decoded write address for the single cycle after the write edge
    assign loadBaseAddressReg   = strb_q[0] | strb_q[2] | strb_q[4] | strb_q[6];
    assign loadBaseWordCountReg = strb_q[1] | strb_q[3] | strb_q[5] | strb_q[7];
    assign loadCommandReg       = strb_q[8];
    assign loadRequestReg       = strb_q[9];
    assign loadSingleMask       = strb_q[10];
    assign loadModeReg          = strb_q[11];
    assign clearInternalFF      = strb_q[12];
    assign masterClear          = strb_q[13];
    assign clearMaskReg         = strb_q[14];
    assign loadAllMask          = strb_q[15];
    assign channel              = channel_q;
    assign internalFF           = ff_q;

    // address/count accesses (addr < 8) move the byte pointer and select the channel;
    // write toggles land on the same edge that raises the strobe
    assign tog = (wr_start || rd_start) && !addr[3];
    assign clr = clearInternalFF || masterClear;

    always_comb begin
        wr_prev_d = wr;
        rd_prev_d = rd;
        strb_d    = wr_start ? 16'd1 << addr : 16'd0;
        channel_d = tog ? addr[2:1] : channel_q;
        ff_d      = clr ? 1'b0 : tog ? !ff_q : ff_q;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_prev_q <= 1'b0;
            rd_prev_q <= 1'b0;
            strb_q    <= '0;
            channel_q <= '0;
            ff_q      <= 1'b0;
        end else begin
            wr_prev_q <= wr_prev_d;
            rd_prev_q <= rd_prev_d;
            strb_q    <= strb_d;
            channel_q <= channel_d;
            ff_q      <= ff_d;
        end
    end

`ifdef ACCESS_ERROR_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = (acc && !IOR_N && !IOW_N) || (rd && addr inside {4'd9, 4'd10, 4'd11, 4'd12, 4'd14, 4'd15});
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) err_q <= 1'b0;
        else          err_q <= err_d;
    end

    assign accessError = err_q;
`endif

endmodule

// File: tb/tb_dma_reference_model.sv
// tb_dma_reference_model: directed self-checking bench for dma_reference_model
module tb_dma_reference_model;

    logic       CLK = 1'b0;
    logic       RESET_N, CS_N, IOR_N, IOW_N, A3, A2, A1, A0, programCondition;
    logic       loadIoDataBufferFromDB, loadIoDataBufferFromStatus;
    logic       readStatusReg, readCurrentAddressReg, readCurrentWordCountReg, readTemporaryReg;
    logic       loadCommandReg, loadModeReg, loadRequestReg, loadSingleMask, loadAllMask;
    logic       clearMaskReg, masterClear, clearInternalFF, loadBaseAddressReg, loadBaseWordCountReg;
    logic [1:0] channel;
    logic       internalFF;
`ifdef ACCESS_ERROR_CHECK_EN
    logic       accessError;
`endif
    logic [9:0] strb;
    logic [4:0] rdv;
    int         passed = 0, failed = 0, total = 0;

    localparam logic [9:0] S_BA = 10'h200, S_WC = 10'h100, S_CMD = 10'h080, S_MODE = 10'h040,
                           S_REQ = 10'h020, S_SM = 10'h010, S_AM = 10'h008, S_CM = 10'h004,
                           S_MC = 10'h002, S_CF = 10'h001;

    dma_reference_model dut (
        .CLK(CLK), .RESET_N(RESET_N), .CS_N(CS_N), .IOR_N(IOR_N), .IOW_N(IOW_N),
        .A3(A3), .A2(A2), .A1(A1), .A0(A0), .programCondition(programCondition),
        .loadIoDataBufferFromDB(loadIoDataBufferFromDB),
        .loadIoDataBufferFromStatus(loadIoDataBufferFromStatus),
        .readStatusReg(readStatusReg), .readCurrentAddressReg(readCurrentAddressReg),
        .readCurrentWordCountReg(readCurrentWordCountReg), .readTemporaryReg(readTemporaryReg),
        .loadCommandReg(loadCommandReg), .loadModeReg(loadModeReg), .loadRequestReg(loadRequestReg),
        .loadSingleMask(loadSingleMask), .loadAllMask(loadAllMask), .clearMaskReg(clearMaskReg),
        .masterClear(masterClear), .clearInternalFF(clearInternalFF),
        .loadBaseAddressReg(loadBaseAddressReg), .loadBaseWordCountReg(loadBaseWordCountReg),
        .channel(channel), .internalFF(internalFF)
`ifdef ACCESS_ERROR_CHECK_EN
        , .accessError(accessError)
`endif
    );

    always #5 CLK = ~CLK;

    assign strb = {loadBaseAddressReg, loadBaseWordCountReg, loadCommandReg, loadModeReg, loadRequestReg,
                   loadSingleMask, loadAllMask, clearMaskReg, masterClear, clearInternalFF};
    assign rdv  = {readStatusReg, loadIoDataBufferFromStatus, readCurrentAddressReg,
                   readCurrentWordCountReg, readTemporaryReg};

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic set_a(input logic [3:0] a);
        {A3, A2, A1, A0} = a;
    endtask

    // one-cycle write; returns just after the edge that raises the strobe
    task automatic wr_one(input logic [3:0] a);
        set_a(a);
        IOW_N = 1'b0;
        tick();
        IOW_N = 1'b1;
        #1;
    endtask

    initial begin
        logic [3:0] tbl_a [4];
        logic [9:0] tbl_s [4];
        tbl_a = '{4'd9, 4'd10, 4'd14, 4'd15};
        tbl_s = '{S_REQ, S_SM, S_CM, S_AM};
        RESET_N = 1'b0; CS_N = 1'b1; IOR_N = 1'b1; IOW_N = 1'b1; programCondition = 1'b1;
        set_a(4'd0);
        tick();
        chk("reset_strb", strb, 10'h0);
        chk("reset_ch", channel, 2'd0);
        chk("reset_ff", internalFF, 1'b0);
`ifdef ACCESS_ERROR_CHECK_EN
        chk("reset_err", accessError, 1'b0);
`endif
        RESET_N = 1'b1;
        CS_N = 1'b0;
        tick();
        wr_one(4'd0);
        chk("pre_ba", strb, S_BA);
        chk("pre_ff", internalFF, 1'b1);
        tick();
        set_a(4'd8);
        IOW_N = 1'b0;
        tick();
        chk("pre_rst_cmd", strb, S_CMD);
        RESET_N = 1'b0;
        #1;
        chk("rst_mid_strb", strb, 10'h0);
        chk("rst_mid_ff", internalFF, 1'b0);
        chk("rst_mid_db", loadIoDataBufferFromDB, 1'b1);
        IOW_N = 1'b1;
        tick();
        RESET_N = 1'b1;
        tick();
        chk("post_rst_strb1", strb, 10'h0);
        tick();
        chk("post_rst_strb2", strb, 10'h0);
        set_a(4'd8);
        IOW_N = 1'b0;
        #1;
        chk("cmd_c1_db", loadIoDataBufferFromDB, 1'b1);
        chk("cmd_c1_strb", strb, 10'h0);
        tick();
        chk("cmd_c2_db", loadIoDataBufferFromDB, 1'b1);
        chk("cmd_c2_strb", strb, S_CMD);
        tick();
        chk("cmd_c3_db", loadIoDataBufferFromDB, 1'b1);
        chk("cmd_c3_strb", strb, 10'h0);
        tick();
        IOW_N = 1'b1;
        #1;
        chk("cmd_c4_db", loadIoDataBufferFromDB, 1'b0);
        chk("cmd_c4_strb", strb, 10'h0);
        tick();
        wr_one(4'd0);
        chk("ba1_strb", strb, S_BA);
        chk("ba1_ff", internalFF, 1'b1);
        chk("ba1_ch", channel, 2'd0);
        tick();
        chk("ba1_end", strb, 10'h0);
        wr_one(4'd0);
        chk("ba2_strb", strb, S_BA);
        chk("ba2_ff", internalFF, 1'b0);
        tick();
        wr_one(4'd0);
        chk("ba3_ff", internalFF, 1'b1);
        tick();
        wr_one(4'd12);
        chk("cff_strb", strb, S_CF);
        tick();
        chk("cff_ff", internalFF, 1'b0);
        chk("cff_end", strb, 10'h0);
        wr_one(4'd5);
        chk("wc5_strb", strb, S_WC);
        chk("wc5_ch", channel, 2'd2);
        chk("wc5_ff", internalFF, 1'b1);
        tick();
        wr_one(4'd11);
        chk("mode_strb", strb, S_MODE);
        chk("mode_ch", channel, 2'd2);
        chk("mode_ff", internalFF, 1'b1);
        tick();
        set_a(4'd8);
        IOR_N = 1'b0;
        #1;
        chk("rd8_dec", rdv, 5'b11000);
        chk("rd8_db", loadIoDataBufferFromDB, 1'b0);
        tick();
        IOR_N = 1'b1;
        #1;
        chk("rd8_ch", channel, 2'd2);
        chk("rd8_ff", internalFF, 1'b1);
        tick();
        set_a(4'd3);
        IOR_N = 1'b0;
        #1;
        chk("rd3_dec", rdv, 5'b00010);
        tick();
        IOR_N = 1'b1;
        #1;
        chk("rd3_ch", channel, 2'd1);
        chk("rd3_ff", internalFF, 1'b0);
        tick();
        set_a(4'd13);
        IOR_N = 1'b0;
        #1;
        chk("rd13_dec", rdv, 5'b00001);
        tick();
        set_a(4'd10);
        #1;
        chk("rd10_dec", rdv, 5'b00000);
        IOR_N = 1'b1;
        tick();
        set_a(4'd6);
        IOR_N = 1'b0;
        #1;
        chk("rd6_dec", rdv, 5'b00100);
        tick();
        IOR_N = 1'b1;
        #1;
        chk("rd6_ch", channel, 2'd3);
        chk("rd6_ff", internalFF, 1'b1);
        tick();
        wr_one(4'd13);
        chk("mc_strb", strb, S_MC);
        tick();
        chk("mc_ff", internalFF, 1'b0);
        wr_one(4'd12);
        chk("prio_strb", strb, S_CF);
        set_a(4'd0);
        IOR_N = 1'b0;
        tick();
        IOR_N = 1'b1;
        #1;
        chk("prio_ff", internalFF, 1'b0);
        chk("prio_ch", channel, 2'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            wr_one(tbl_a[i]);
            chk($sformatf("map_a%0d", tbl_a[i]), strb, tbl_s[i]);
            tick();
        end
        programCondition = 1'b0;
        set_a(4'd8);
        IOW_N = 1'b0;
        #1;
        chk("npc_db", loadIoDataBufferFromDB, 1'b0);
        tick();
        chk("npc_strb", strb, 10'h0);
        IOW_N = 1'b1;
        programCondition = 1'b1;
        CS_N = 1'b1;
        tick();
        IOW_N = 1'b0;
        #1;
        chk("ncs_db", loadIoDataBufferFromDB, 1'b0);
        tick();
        chk("ncs_strb", strb, 10'h0);
        IOW_N = 1'b1;
        CS_N = 1'b0;
        tick();
        IOW_N = 1'b0;
        IOR_N = 1'b0;
        #1;
        chk("both_db", loadIoDataBufferFromDB, 1'b0);
        chk("both_rd", rdv, 5'b00000);
        tick();
`ifdef ACCESS_ERROR_CHECK_EN
        chk("both_err", accessError, 1'b1);
`endif
        IOW_N = 1'b1;
        IOR_N = 1'b1;
        tick();
        chk("both_strb", strb, 10'h0);
`ifdef ACCESS_ERROR_CHECK_EN
        chk("both_err_end", accessError, 1'b0);
        set_a(4'd9);
        IOR_N = 1'b0;
        tick();
        IOR_N = 1'b1;
        #1;
        chk("rd9_err", accessError, 1'b1);
        tick();
        chk("rd9_err_end", accessError, 1'b0);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dma_reference_model.md
Name: dma_reference_model

Overview:
- Cycle-accurate reference decoder for the 8237-style DMA controller's CPU programming interface.
- Watches the bus-interface CPU signals while the controller is in program condition.
- Produces one-hot strobes that predict which internal register the DMA should load or drive, plus a shadow byte-pointer flip-flop.
- Instantiated beside the DMA inside the SVA checker; its outputs are antecedents for register-load assertions.

Parameters:
- NUM_CH, 4, number of DMA channels. Fixed at 4; the 4-bit register map relies on it.

Ports:
- CLK  input  1  system clock, rising edge
- RESET_N  input  1  asynchronous active-low reset
- CS_N  input  1  chip select, active low
- IOR_N  input  1  I/O read strobe, active low
- IOW_N  input  1  I/O write strobe, active low
- A3, A2, A1, A0  input  1 each  register address (A3 = MSB)
- programCondition  input  1  DMA is idle and slave-programmable
- loadIoDataBufferFromDB  output  1  combinational, write cycle in progress
- loadIoDataBufferFromStatus  output  1  combinational, status read in progress
- readStatusReg, readCurrentAddressReg, readCurrentWordCountReg, readTemporaryReg  output  1 each  combinational read decodes
- loadCommandReg, loadModeReg, loadRequestReg, loadSingleMask, loadAllMask, clearMaskReg, masterClear, clearInternalFF  output  1 each  registered one-cycle strobes
- loadBaseAddressReg, loadBaseWordCountReg  output  1 each  registered strobes; base and current registers are loaded together
- channel  output  2  channel targeted by the latest address/count access
- internalFF  output  1  shadow byte-pointer flip-flop (0 = low byte, 1 = high byte)

Behaviour:
- Access qualifiers:
  - acc = !CS_N && programCondition.
  - wr = acc && !IOW_N && IOR_N.
  - rd = acc && !IOR_N && IOW_N.
  - Both strobes low at once: neither wr nor rd.
- Combinational decodes (same cycle as the strobe), with addr = {A3,A2,A1,A0}:
  - loadIoDataBufferFromDB = wr.
  - readCurrentAddressReg = rd && addr<8 && A0==0.
  - readCurrentWordCountReg = rd && addr<8 && A0==1.
  - readStatusReg = loadIoDataBufferFromStatus = rd && addr==8.
  - readTemporaryReg = rd && addr==13.
  - All other read addresses decode nothing.
- Registered write strobes:
  - On the first cycle of wr (wr high, wr low in the previous cycle), latch addr.
  - Assert exactly one strobe for exactly one cycle on the next cycle, so the DMA's ioDataBuffer already holds DB.
  - Address map: 0,2,4,6 loadBaseAddressReg; 1,3,5,7 loadBaseWordCountReg; 8 loadCommandReg; 9 loadRequestReg; 10 loadSingleMask; 11 loadModeReg; 12 clearInternalFF; 13 masterClear; 14 clearMaskReg; 15 loadAllMask.
  - A write held low for N cycles produces one strobe.
- channel:
  - Updated to addr[2:1] when an address/count write strobe fires.
  - Also updated on the first cycle of an address/count read.
- internalFF:
  - Toggles one cycle after the start of each address/count write, coincident with the strobe.
  - Toggles at the first cycle of each address/count read.
  - Cleared to 0 by clearInternalFF or masterClear; clear takes priority over toggle.
- Reset (RESET_N low, asynchronous):
  - All registered strobes 0, channel 0, internalFF 0, latched address 0, edge-detect history 0.
  - Combinational outputs follow inputs.
- programCondition dropping mid-write: an edge already detected still produces its strobe; no new edge is detected until programCondition returns.

Optional Feature:
- Macro ACCESS_ERROR_CHECK_EN. When defined, add output accessError (1 bit, registered).
- accessError is set for one cycle after any of:
  - acc with both IOR_N and IOW_N low;
  - a read from addresses 9–12, 14 or 15.
- Reset value 0.
- When the macro is undefined, the port and logic are absent and all other behaviour is unchanged.

Test Plan:
- RESET_N low mid-write of addr 8 → all registered strobes 0 immediately, internalFF 0, no loadCommandReg after release.
- CS_N=0, programCondition=1, IOW_N low 3 cycles at addr 8 → loadIoDataBufferFromDB high 3 cycles; loadCommandReg high exactly 1 cycle, the cycle after IOW_N falls.
- Writes to addr 0 then addr 0 → two loadBaseAddressReg pulses, channel=0, internalFF 0→1→0; then write addr 12 → clearInternalFF pulse, internalFF=0.
- Write addr 5 → loadBaseWordCountReg pulse, channel=2; write addr 11 → loadModeReg only.
- IOR_N low at addr 8 → readStatusReg and loadIoDataBufferFromStatus high same cycle; IOR_N low at addr 3 → readCurrentWordCountReg, channel=1.
- programCondition=0 or CS_N=1 during IOW_N low at addr 8 → no decode outputs, no strobe; with ACCESS_ERROR_CHECK_EN, IOR_N=IOW_N=0 under acc → accessError pulse.
